// File: rtl/bcd_conversion_scheduler.sv
// bcd_conversion_scheduler: round-robin sharing of one registered binary-to-BCD converter among stopwatch fields
module bcd_conversion_scheduler #(
  parameter int NUM_FIELDS = 3,
  parameter int BIN_W      = 6,
  parameter int CONV_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FIELDS*BIN_W-1:0]   field_bin,
  input  logic [NUM_FIELDS-1:0]         field_req,
  output logic [BIN_W-1:0]              conv_bin,
  input  logic [3:0]                    conv_tens,
  input  logic [3:0]                    conv_units,
  output logic [NUM_FIELDS*8-1:0]       bcd_out,
  output logic [NUM_FIELDS-1:0]         field_done,
  output logic                          busy
);
  localparam int PW = $clog2(NUM_FIELDS);
  localparam int CW = $clog2(CONV_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;
  state_t                  state_q;
  logic [NUM_FIELDS-1:0]   pending_q, pending_d, clr_mask;
  logic [PW-1:0]           rr_q, g_q, gnt_idx, j_c;
  logic                    gnt_found;
  logic [CW-1:0]           cnt_q;
  logic [BIN_W-1:0]        conv_bin_q;
  logic [NUM_FIELDS*8-1:0] bcd_q;
  logic [NUM_FIELDS-1:0]   done_q;
  // Round-robin search: first pending field after the last one served.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j_c       = '0;
    for (int k = 1; k <= NUM_FIELDS; k++) begin
      j_c = PW'((int'(rr_q) + k) % NUM_FIELDS);
      if (!gnt_found && pending_q[j_c]) begin
        gnt_found = 1'b1;
        gnt_idx   = j_c;
      end
    end
  end
  // A new request on the grant edge survives the clear, so the field is served again later.
  always_comb begin
    clr_mask  = (state_q == IDLE && gnt_found) ? (NUM_FIELDS'(1) << gnt_idx) : '0;
    pending_d = (pending_q & ~clr_mask) | field_req;
  end
  // Grant, wait out converter latency, then capture digits for the granted field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      rr_q       <= PW'(NUM_FIELDS - 1);
      g_q        <= '0;
      cnt_q      <= '0;
      conv_bin_q <= '0;
      bcd_q      <= '0;
      done_q     <= '0;
    end else begin
      pending_q <= pending_d;
      done_q    <= '0;
      case (state_q)
        IDLE: if (gnt_found) begin
          g_q        <= gnt_idx;
          rr_q       <= gnt_idx;
          conv_bin_q <= field_bin[gnt_idx*BIN_W +: BIN_W];
          cnt_q      <= CW'(CONV_LAT - 1);
          state_q    <= WAIT;
        end
        WAIT: if (cnt_q == '0) state_q <= CAPTURE; else cnt_q <= cnt_q - 1'b1;
        CAPTURE: begin
          bcd_q[g_q*8 +: 8] <= {conv_tens, conv_units};
          done_q[g_q]       <= 1'b1;
          state_q           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign conv_bin   = conv_bin_q;
  assign bcd_out    = bcd_q;
  assign field_done = done_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_bcd_conversion_scheduler.sv
// tb_bcd_conversion_scheduler: directed checks of the shared BCD converter scheduler at latency 1 and 3
module tb_bcd_conversion_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] bin_a = '0, bin_b = '0;
  logic [2:0]  req_a = '0, req_b = '0;
  logic [5:0]  cb_a, cb_b;
  logic [7:0]  pa;
  logic [7:0]  pb [3];
  logic [23:0] bcd_a, bcd_b;
  logic [2:0]  done_a, done_b;
  logic        busy_a, busy_b;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  bcd_conversion_scheduler #(.NUM_FIELDS(3), .BIN_W(6), .CONV_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .field_bin(bin_a), .field_req(req_a), .conv_bin(cb_a),
    .conv_tens(pa[7:4]), .conv_units(pa[3:0]), .bcd_out(bcd_a), .field_done(done_a), .busy(busy_a));
  bcd_conversion_scheduler #(.NUM_FIELDS(3), .BIN_W(6), .CONV_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .field_bin(bin_b), .field_req(req_b), .conv_bin(cb_b),
    .conv_tens(pb[2][7:4]), .conv_units(pb[2][3:0]), .bcd_out(bcd_b), .field_done(done_b), .busy(busy_b));
  // Converter models: one register stage for dut_a, three for dut_b.
  always @(posedge clk) begin
    pa    <= {4'(cb_a / 6'd10), 4'(cb_a % 6'd10)};
    pb[0] <= {4'(cb_b / 6'd10), 4'(cb_b % 6'd10)};
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    cyc(2);
    chk("rst_bcd", 32'(bcd_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_cbin", 32'(cb_a), 0);
    reset = 1'b0;
    // T3: all three fields at once, field 0 first after reset
    bin_a = {6'd12, 6'd59, 6'd7}; req_a = 3'b111;
    cyc(1); req_a = 3'b000;
    chk("t3_idle_busy", 32'(busy_a), 0);
    cyc(1);
    chk("t3_g0_cbin", 32'(cb_a), 7);
    cyc(2);
    chk("t3_done0", 32'(done_a), 3'b001);
    chk("t3_bcd0", 32'(bcd_a[7:0]), 8'h07);
    chk("t3_busy_at_done", 32'(busy_a), 0);
    cyc(1);
    chk("t3_g1_cbin", 32'(cb_a), 59);
    chk("t3_done_clr", 32'(done_a), 0);
    cyc(2);
    chk("t3_done1", 32'(done_a), 3'b010);
    cyc(3);
    chk("t3_done2", 32'(done_a), 3'b100);
    chk("t3_bcd_all", 32'(bcd_a), 24'h125907);
    // T2: single request on field 1
    cyc(1);
    bin_a = {6'd12, 6'd45, 6'd7}; req_a = 3'b010;
    cyc(1); req_a = 3'b000;
    chk("t2_busy_pend", 32'(busy_a), 0);
    cyc(1);
    chk("t2_busy_wait", 32'(busy_a), 1);
    chk("t2_cbin", 32'(cb_a), 45);
    cyc(1);
    chk("t2_busy_cap", 32'(busy_a), 1);
    chk("t2_done_early", 32'(done_a), 0);
    cyc(1);
    chk("t2_done", 32'(done_a), 3'b010);
    chk("t2_bcd", 32'(bcd_a), 24'h124507);
    chk("t2_busy_end", 32'(busy_a), 0);
    cyc(1);
    chk("t2_done_pulse", 32'(done_a), 0);
    // T1: reset mid-WAIT, then field 2 served
    bin_a = {6'd12, 6'd45, 6'd5}; req_a = 3'b001;
    cyc(1); req_a = 3'b000;
    cyc(1);
    chk("t1_in_wait", 32'(busy_a), 1);
    reset = 1'b1;
    #1;
    chk("t1_rst_busy", 32'(busy_a), 0);
    chk("t1_rst_bcd", 32'(bcd_a), 0);
    chk("t1_rst_cbin", 32'(cb_a), 0);
    chk("t1_rst_done", 32'(done_a), 0);
    cyc(1); reset = 1'b0;
    bin_a = {6'd38, 6'd45, 6'd5}; req_a = 3'b100;
    cyc(1); req_a = 3'b000;
    cyc(1);
    chk("t1_cbin", 32'(cb_a), 38);
    cyc(2);
    chk("t1_done", 32'(done_a), 3'b100);
    chk("t1_bcd", 32'(bcd_a), 24'h380000);
    // T4: field 0 held high, re-served after fields 1 and 2
    bin_a = {6'd34, 6'd21, 6'd0}; req_a = 3'b111;
    cyc(1); req_a = 3'b001;
    cyc(3);
    chk("t4_done0a", 32'(done_a), 3'b001);
    chk("t4_bcd0a", 32'(bcd_a[7:0]), 8'h00);
    cyc(3);
    chk("t4_done1", 32'(done_a), 3'b010);
    bin_a = {6'd34, 6'd21, 6'd63};
    cyc(3);
    chk("t4_done2", 32'(done_a), 3'b100);
    chk("t4_bcd_mid", 32'(bcd_a), 24'h342100);
    req_a = 3'b000;
    cyc(1);
    chk("t4_cbin63", 32'(cb_a), 63);
    cyc(2);
    chk("t4_done0b", 32'(done_a), 3'b001);
    chk("t4_bcd_end", 32'(bcd_a), 24'h342163);
    // T5: value changes between request and grant
    bin_a = {6'd10, 6'd21, 6'd63}; req_a = 3'b100;
    cyc(1); req_a = 3'b000; bin_a = {6'd11, 6'd21, 6'd63};
    cyc(1);
    chk("t5_cbin", 32'(cb_a), 11);
    cyc(2);
    chk("t5_done", 32'(done_a), 3'b100);
    chk("t5_bcd2", 32'(bcd_a[23:16]), 8'h11);
    cyc(3);
    chk("t5_no_redo", 32'(done_a), 0);
    chk("t5_idle", 32'(busy_a), 0);
    // T6: latency-3 instance
    bin_b = {6'd0, 6'd27, 6'd0}; req_b = 3'b010;
    cyc(1); req_b = 3'b000;
    cyc(1);
    chk("t6_cbin_e1", 32'(cb_b), 27);
    chk("t6_busy", 32'(busy_b), 1);
    cyc(2);
    chk("t6_cbin_e3", 32'(cb_b), 27);
    chk("t6_done_e3", 32'(done_b), 0);
    cyc(1);
    chk("t6_done_e4", 32'(done_b), 0);
    chk("t6_busy_cap", 32'(busy_b), 1);
    cyc(1);
    chk("t6_done", 32'(done_b), 3'b010);
    chk("t6_bcd", 32'(bcd_b), 24'h002700);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
